// File: rtl/nn_output_serializer.sv
// Buffers whole result vectors in a small FIFO and replays each one as a
// valid/ready element stream; vectors arriving while full are dropped and counted.
module nn_output_serializer #(
  parameter int NUM_DATA_INPUTS  = 1,
  parameter int INPUT_DATA_WIDTH = 10,
  parameter int FIFO_DEPTH       = 4,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   data_in_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]            data_in [NUM_DATA_INPUTS-1:0],
  output logic                                   data_in_ready,
  output logic                                   data_out_valid,
  output logic [INPUT_DATA_WIDTH-1:0]            data_out,
  output logic [((NUM_DATA_INPUTS > 1) ? $clog2(NUM_DATA_INPUTS) : 1)-1:0] data_out_index,
  output logic                                   data_out_last,
  input  logic                                   data_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count,
  output logic                                   overflow,
  output logic [DROP_COUNT_WIDTH-1:0]            drop_count
);

  localparam int W     = INPUT_DATA_WIDTH;
  localparam int N     = NUM_DATA_INPUTS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {EMPTY, SEND} state_t;

  logic [N*W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_index;
  logic                  r_overflow;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;
  state_t                r_state;

  logic [N*W-1:0]        w_vec;
  logic [N*W-1:0]        w_rd_vec;
  logic                  w_full, w_push, w_drop, w_accept, w_pop;
  logic [CNT_W-1:0]      w_count_nxt;
  state_t                w_state_nxt;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign w_vec[g*W +: W] = data_in[g];
  end

  // Full/drop decisions use the pre-edge count so a same-cycle pop never frees a slot.
  assign w_full   = (r_count == FULL_CNT);
  assign w_push   = data_in_valid & ~w_full;
  assign w_drop   = data_in_valid & w_full;
  assign w_accept = data_out_valid & data_out_ready;
  assign w_pop    = w_accept & data_out_last;

  assign w_rd_vec       = r_mem[r_rd_ptr];
  assign data_out       = w_rd_vec[r_index*W +: W];
  assign data_out_index = r_index;
  assign data_out_last  = (r_index == LAST_IDX);
  assign data_out_valid = (r_state == SEND);
  assign data_in_ready  = ~w_full;
  assign fifo_count     = r_count;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_count_nxt != '0) w_state_nxt = SEND;
      SEND:    if (w_count_nxt == '0) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_index      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_accept) begin
        if (data_out_last) begin
          r_index  <= '0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else begin
          r_index  <= r_index + 1'b1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_output_serializer.sv
// Directed bench for nn_output_serializer: table of per-cycle stimulus and
// expected outputs, plus a hand-written drop-counter saturation sequence.
module tb_nn_output_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in_valid;
  logic [9:0] data_in [2:0];
  logic       data_in_ready;
  logic       data_out_valid;
  logic [9:0] data_out;
  logic [1:0] data_out_index;
  logic       data_out_last;
  logic       data_out_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [3:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  nn_output_serializer #(
    .NUM_DATA_INPUTS (3),
    .INPUT_DATA_WIDTH(10),
    .FIFO_DEPTH      (4),
    .DROP_COUNT_WIDTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .data_in_ready (data_in_ready),
    .data_out_valid(data_out_valid),
    .data_out      (data_out),
    .data_out_index(data_out_index),
    .data_out_last (data_out_last),
    .data_out_ready(data_out_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic vin;
    int   k;
    logic rdy;
    logic ev;
    int   ek;
    int   eidx;
    int   ecnt;
    logic eovf;
    int   edrp;
  } row_t;

  row_t rows[$];

  // Element j of test vector k; vector 0 is {0x003,0x002,0x001}.
  function automatic logic [9:0] vec(int k, int j);
    return 10'(k * 64 + j + 1);
  endfunction

  task automatic add(logic r, logic vin, int k, logic rdy, logic ev, int ek,
                     int eidx, int ecnt, logic eovf, int edrp);
    row_t x;
    x.rst = r; x.vin = vin; x.k = k; x.rdy = rdy; x.ev = ev; x.ek = ek;
    x.eidx = eidx; x.ecnt = ecnt; x.eovf = eovf; x.edrp = edrp;
    rows.push_back(x);
  endtask

  task automatic drive(logic r, logic vin, int k, logic rdy);
    rst = r;
    data_in_valid = vin;
    for (int j = 0; j < 3; j++) data_in[j] = vec(k, j);
    data_out_ready = rdy;
  endtask

  task automatic check(string nm, logic ev, int ek, int eidx, int ecnt,
                       logic eovf, int edrp);
    logic [9:0] edat;
    logic [9:0] adat;
    logic       elast;
    logic       eirdy;
    logic [22:0] exp_v;
    logic [22:0] act_v;
    edat  = vec(ek, eidx);
    elast = (eidx == 2);
    eirdy = (ecnt != 4);
    adat  = ev ? data_out : edat;
    exp_v = {ev, 2'(eidx), elast, 3'(ecnt), eirdy, eovf, 4'(edrp), edat};
    act_v = {data_out_valid, data_out_index, data_out_last, fifo_count,
             data_in_ready, overflow, drop_count, adat};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got v=%0d dat=%h idx=%0d last=%0d cnt=%0d in_rdy=%0d ovf=%0d drp=%0d, want v=%0d dat=%h idx=%0d last=%0d cnt=%0d in_rdy=%0d ovf=%0d drp=%0d",
               nm, data_out_valid, data_out, data_out_index, data_out_last,
               fifo_count, data_in_ready, overflow, drop_count,
               ev, edat, eidx, elast, ecnt, eirdy, eovf, edrp);
    end
  endtask

  initial begin
    // Single vector, ready high
    add(0,1,0,1, 0,0,0,0,0,0);
    add(0,0,0,1, 1,0,0,1,0,0);
    add(0,0,0,1, 1,0,1,1,0,0);
    add(0,0,0,1, 1,0,2,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,0);
    // Backpressure holds element 0
    add(0,1,8,1, 0,0,0,0,0,0);
    add(0,0,0,0, 1,8,0,1,0,0);
    add(0,0,0,0, 1,8,0,1,0,0);
    add(0,0,0,1, 1,8,0,1,0,0);
    add(0,0,0,1, 1,8,1,1,0,0);
    add(0,0,0,1, 1,8,2,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,0);
    // Five pushes into a stalled FIFO: fifth dropped
    add(0,1,1,0, 0,0,0,0,0,0);
    add(0,1,2,0, 1,1,0,1,0,0);
    add(0,1,3,0, 1,1,0,2,0,0);
    add(0,1,4,0, 1,1,0,3,0,0);
    add(0,1,5,0, 1,1,0,4,0,0);
    add(0,0,0,0, 1,1,0,4,1,1);
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 3; j++)
        add(0,0,0,1, 1,k,j,5-k,1,1);
    add(0,0,0,1, 0,0,0,0,1,1);
    // Push on last-beat pop keeps count; push at full with pop still drops
    add(0,1,6,0, 0,0,0,0,1,1);
    add(0,1,7,0, 1,6,0,1,1,1);
    add(0,0,0,1, 1,6,0,2,1,1);
    add(0,0,0,1, 1,6,1,2,1,1);
    add(0,1,9,1, 1,6,2,2,1,1);
    add(0,1,10,0, 1,7,0,2,1,1);
    add(0,1,11,0, 1,7,0,3,1,1);
    add(0,0,0,1, 1,7,0,4,1,1);
    add(0,0,0,1, 1,7,1,4,1,1);
    add(0,1,12,1, 1,7,2,4,1,1);
    add(0,0,0,1, 1,9,0,3,1,2);
    add(0,0,0,1, 1,9,1,3,1,2);
    // Reset mid-vector, then a fresh vector starts at index 0
    add(1,0,0,1, 1,9,2,3,1,2);
    add(0,1,14,1, 0,0,0,0,0,0);
    add(0,0,0,1, 1,14,0,1,0,0);
    add(0,0,0,1, 1,14,1,1,0,0);
    add(0,0,0,1, 1,14,2,1,0,0);
    add(0,0,0,1, 0,0,0,0,0,0);

    drive(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("reset_state", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      drive(rows[i].rst, rows[i].vin, rows[i].k, rows[i].rdy);
      check($sformatf("row%0d", i), rows[i].ev, rows[i].ek, rows[i].eidx,
            rows[i].ecnt, rows[i].eovf, rows[i].edrp);
    end

    // Saturation: fill then keep pushing with output stalled
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(0, 1, 13, 0);
      check($sformatf("sat_push%0d", i), (i > 1), 13, 0,
            (i - 1 > 4) ? 4 : i - 1, (i - 1 > 4),
            (i - 5 <= 0) ? 0 : ((i - 5 > 15) ? 15 : i - 5));
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("sat_final", 1, 13, 0, 4, 1, 15);
    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    check("sat_reset", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_output_serializer.md
Name: nn_output_serializer

Overview:
- Downstream stage of the neural_network top. It consumes the parallel result vector (data_out_valid / data_out[NUM_DATA_INPUTS]) and buffers whole vectors in a small FIFO.
- It then emits the vector one element per beat on a valid/ready stream, with element index and last flag.
- The network drives its output with ready tied high, so this block must absorb bursts. When full it drops vectors and reports the loss instead of stalling.

Parameters:
- NUM_DATA_INPUTS, 1, elements per result vector (N); must be ≥1.
- INPUT_DATA_WIDTH, 10, bits per element (W).
- FIFO_DEPTH, 4, vectors buffered; must be a power of 2, ≥2.
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- data_in_valid  in  1  result vector present (from network data_out_valid).
- data_in  in  W x N (unpacked [N-1:0])  result vector.
- data_in_ready  out  1  space available (= count != FIFO_DEPTH); informational, upstream may ignore it.
- data_out_valid  out  1  element beat valid.
- data_out  out  W  current element.
- data_out_index  out  max(1,$clog2(N))  element index within the vector.
- data_out_last  out  1  high on element N-1.
- data_out_ready  in  1  downstream accepts beat.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  vectors stored, including the one being serialized.
- overflow  out  1  sticky; a vector was dropped.
- drop_count  out  DROP_COUNT_WIDTH  vectors dropped; saturates at all-ones.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Pointers, fifo_count, index, overflow and drop_count all go to 0.
  - data_out_valid=0, data_in_ready=1.
  - Memory contents are not reset and must never be observable.
  - Reset mid-vector abandons the remaining elements. After reset the first beat is always index 0.
- Push: data_in_valid & (fifo_count != FIFO_DEPTH) writes the whole vector at wr_ptr, then wr_ptr++ (wraps mod FIFO_DEPTH).
- Drop: data_in_valid & (fifo_count == FIFO_DEPTH), evaluated on the pre-edge count.
  - The vector is discarded; overflow<=1; drop_count increments unless all-ones.
  - A pop in the same cycle does NOT rescue the push. data_in_ready has no combinational path from data_out_ready.
- Serializer (two-state FSM, EMPTY / SEND):
  - data_out_valid = (fifo_count != 0).
  - data_out = mem[rd_ptr][index], data_out_index = index, data_out_last = (index == N-1).
  - On beat accept (valid & ready): if index == N-1, then index<=0, rd_ptr++ (wrap) and the vector pops; otherwise index++.
  - While valid & ~ready, data_out, index and last hold stable.
- Count update:
  - count += push − pop. Simultaneous push and pop leaves the count unchanged.
  - Push into an empty FIFO takes effect next cycle: latency is one cycle from push edge to data_out_valid.
- Throughput: 1 element/cycle. A vector of N elements occupies the output for N accepted beats.
  - Sustained input above 1 vector per N cycles eventually overflows by design.
- N=1: index is stuck at 0, last is always 1, every accepted beat pops.
- overflow clears only on reset.

Test Plan:
1. N=3, W=10, DEPTH=4, data_out_ready=1. Push {0x003,0x002,0x001} (data_in[0]=0x001) at cycle 0 -> cycles 1–3 give valid=1, data 0x001/0x002/0x003, index 0/1/2, last only at cycle 3; cycle 4 gives valid=0, fifo_count=0.
2. Same push, ready=0 during cycles 1–2 -> data_out=0x001, index=0 held stable; beats resume cycle 3, last at cycle 5.
3. ready=0, push 5 vectors on consecutive cycles -> fifo_count=4, data_in_ready=0 after 4th push; 5th dropped, overflow=1, drop_count=1. Draining yields vectors 1–4 in order, 12 beats.
4. fifo_count=2, push coincides with the last-element accept -> fifo_count stays 2. Then at count=4 with a pop in the same cycle, push -> dropped, drop_count +1, count=3.
5. Reset asserted after index 1 of a vector is accepted -> next cycle valid=0, count=0, overflow=0, drop_count=0. A new push produces index 0 first.
6. drop_count preset by forcing 0xFFFF drops (DROP_COUNT_WIDTH=4: 16 drops) -> saturates at 0xF, overflow stays 1.
